msk_g4mul_hpc3_sched: RTL
=========================

// Module: msk_g4mul_hpc3_sched
// PURPOSE
//  Round-robin scheduler sharing one masked HPC3 G(4) multiplier (latency 1) among N requesters.
//  - Arbitrates requests and drives the multiplier's a/b sharings and fresh randomness.
//  - Generates the a_prev (latency-1) copy the multiplier needs.
//  - Tags each result with its requester ID and buffers it in a 2-entry output FIFO with valid/ready.
//  - Sits between masked S-box/field-arithmetic clients and the multiplier instance.
// PARAMETERS
//  d      2 (`DEFAULTSHARES)  number of shares per bit
//  N      4                   number of requesters, >= 2
//  RND_W  localparam 2*d*(d-1)  fresh random bits consumed per multiplication
//  IDW    localparam max(1,$clog2(N))  width of the requester tag
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   N        request k valid; held with its data until in_ready[k]
//  in_ready     out  N        one-hot-or-zero grant; issue = in_valid[k] & in_ready[k]
//  in_a0,in_a1  in   N*d      operand a sharings (bit 0 / bit 1), requester k at [k*d +: d]
//  in_b0,in_b1  in   N*d      operand b sharings, same packing
//  rnd_valid    in   1        fresh randomness available on rnd
//  rnd_ready    out  1        randomness consumed this cycle (== issue)
//  rnd          in   RND_W    fresh randomness
//  mul_a0,mul_a1            out d      multiplier a sharing (latency 0)
//  mul_b0,mul_b1            out d      multiplier b sharing (latency 0)
//  mul_a0_prev,mul_a1_prev  out d      registered copy of mul_a0/mul_a1 (latency 1)
//  mul_rnd      out  RND_W    multiplier randomness
//  mul_out0,mul_out1        in   d      multiplier result, valid 1 cycle after issue
//  out_valid    out  1        FIFO head valid
//  out_ready    in   1        consumer accepts head; pop = out_valid & out_ready
//  out_id       out  IDW      requester index of head result
//  out0,out1    out  d        head result sharing
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge):
//    - ptr=0, inflight=0, FIFO emptied, a_prev regs=0.
//    - out_valid=0, out_id=0, out0/out1=0 next cycle.
//    - An in-flight result is discarded. in_ready=0 and rnd_ready=0 while rst is high.
//  - Grant: first k with in_valid[k], searching ptr, ptr+1, ... mod N. After an issue, ptr <= grant+1 mod N.
//  - issue_ok = rnd_valid & (occ + inflight - pop < 2), where occ = FIFO count (0..2).
//  - Issue at cycle t: in_ready[grant]=1 and rnd_ready=1, only when issue_ok and some valid.
//    - Same cycle: mul_a*/mul_b* = grant's shares; mul_rnd = rnd; inflight <= 1, tag_reg <= grant.
//  - No issue: mul_a*, mul_b*, mul_rnd driven all-zero. Never leave a previous operand on the bus.
//  - mul_a*_prev <= mul_a* every cycle, unconditionally, so a_prev always equals the cycle t-1 issue.
//  - Cycle t+1: if inflight, push {tag_reg, mul_out0, mul_out1} into the FIFO. inflight <= issue at t+1.
//  - Back-to-back issues are allowed: 1 result/cycle while out_ready=1.
//  - FIFO push and pop in the same cycle: occ unchanged. A push into an empty FIFO appears at out_* the next cycle.
//  - The FIFO never overflows, because issue_ok guarantees a free slot. A push when full is an assertion failure.
//  - Output stalls are legal: out_* hold stable while out_valid & !out_ready.
//  - Share masking: never XOR or combine shares of different indices. Shares are muxed and registered per index only.
//  - in_ready must not depend combinationally on out0/out1 or mul_out*.
// TESTING (d=2, N=4; check recombined out0/out1 against a G4_mul golden model of the recombined a,b)
//  - Reset, then in_valid=4'b0001, a={01,10}, b={11,00}, rnd_valid=1
//    -> in_ready=0001 at cycle 0; out_valid=1 at cycle 2 with out_id=0 and correct product.
//  - in_valid=4'b1111 held, out_ready=1, rnd_valid=1
//    -> grants 0,1,2,3,0 on consecutive cycles; results out in the same order, one per cycle.
//  - Streaming with out_ready=0
//    -> exactly 2 issues, then in_ready=0; out_ready=1 -> out_id sequence resumes without loss.
//  - rnd_valid toggled 1,0,1 with in_valid=4'b0100
//    -> issue only on cycles with rnd_valid=1; mul_rnd/mul_a*/mul_b* are zero on non-issue cycles.
//  - rst asserted the cycle after an issue
//    -> no result pushed; out_valid=0; ptr=0; next grant goes to the lowest valid index.
//  - Every issue cycle t
//    -> mul_a*_prev at cycle t+1 equals mul_a* at cycle t; rnd_ready equals |(in_valid & in_ready).

Source files
------------

// File: rtl/msk_g4mul_hpc3_sched.sv
// ---------------------------------------------------------------------------
// msk_g4mul_hpc3_sched
//
// Round-robin scheduler that time-shares one masked HPC3 G(4) multiplier
// (latency 1) among N requesters. Each cycle it picks at most one request,
// routes that requester's a/b sharings and a fresh randomness word to the
// multiplier, and keeps a registered copy of the a sharing (a_prev). One
// cycle later the multiplier result is tagged with the requester index and
// written into a 2-entry output FIFO.
//
// Handshakes (all of them): a transfer happens in a cycle where both valid
// and ready are high at the rising edge. Valid may not be withdrawn and its
// data may not change until the transfer. Ready may depend on valid in the
// same cycle.
//   request k : in_valid[k] / in_ready[k]   (in_ready is one-hot or zero)
//   randomness: rnd_valid   / rnd_ready     (rnd_ready == request issue)
//   result    : out_valid   / out_ready
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid, in_ready          per-requester request handshake (N bits)
//   in_a0, in_a1, in_b0, in_b1  operand sharings, requester k at [k*d +: d]
//   rnd_valid, rnd_ready, rnd   fresh randomness (RND_W bits)
//   mul_a0, mul_a1, mul_b0, mul_b1   operand sharings to the multiplier
//   mul_a0_prev, mul_a1_prev    mul_a0/mul_a1 delayed by one cycle
//   mul_rnd                     randomness to the multiplier
//   mul_out0, mul_out1          multiplier result, valid 1 cycle after issue
//   out_valid, out_ready        FIFO head handshake
//   out_id, out0, out1          FIFO head: requester tag and result sharing
//
// Shares are only ever muxed and registered index by index; no two shares
// of a value are combined anywhere in this block.
// ---------------------------------------------------------------------------
module msk_g4mul_hpc3_sched #(
    parameter  int d     = 2,
    parameter  int N     = 4,
    localparam int RND_W = 2 * d * (d - 1),
    localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*d-1:0]   in_a0,
    input  logic [N*d-1:0]   in_a1,
    input  logic [N*d-1:0]   in_b0,
    input  logic [N*d-1:0]   in_b1,

    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd,

    output logic [d-1:0]     mul_a0,
    output logic [d-1:0]     mul_a1,
    output logic [d-1:0]     mul_b0,
    output logic [d-1:0]     mul_b1,
    output logic [d-1:0]     mul_a0_prev,
    output logic [d-1:0]     mul_a1_prev,
    output logic [RND_W-1:0] mul_rnd,
    input  logic [d-1:0]     mul_out0,
    input  logic [d-1:0]     mul_out1,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id,
    output logic [d-1:0]     out0,
    output logic [d-1:0]     out1
);

    // Reduce an arbitrary non-negative index modulo N to a tag.
    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'(v % N);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [IDW-1:0] ptr_q;        // first requester searched this cycle
    logic           inflight_q;   // an issue happened last cycle
    logic [IDW-1:0] tag_q;        // requester of that issue

    logic [1:0]     occ_q;        // FIFO occupancy 0..2
    logic           wr_q;         // FIFO write slot
    logic           rd_q;         // FIFO read slot
    logic [IDW-1:0] id_mem [2];
    logic [d-1:0]   r0_mem [2];
    logic [d-1:0]   r1_mem [2];

    // -----------------------------------------------------------------------
    // Round-robin grant: first valid requester at ptr, ptr+1, ... mod N
    // -----------------------------------------------------------------------
    logic           any_valid;
    logic [IDW-1:0] grant_idx;

    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!any_valid && in_valid[wrap_idx(int'(ptr_q) + i)]) begin
                any_valid = 1'b1;
                grant_idx = wrap_idx(int'(ptr_q) + i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Issue decision
    // A new issue produces a push one cycle later, so it is allowed only if
    // the FIFO entries that will still be held after this cycle's pop, plus
    // the result already in flight, leave at least one slot free. This only
    // uses registered state and out_ready, never the result data.
    // -----------------------------------------------------------------------
    logic       pop;
    logic       push;
    logic [2:0] load;
    logic       issue_ok;
    logic       issue;

    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;
    assign load      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign issue_ok  = rnd_valid & (load < 3'd2);
    assign issue     = !rst & issue_ok & any_valid;

    assign in_ready  = issue ? (N'(1) << grant_idx) : '0;
    assign rnd_ready = issue;

    // -----------------------------------------------------------------------
    // Multiplier operand bus: granted shares on an issue, all-zero otherwise
    // so that a stale operand never lingers on the multiplier inputs.
    // -----------------------------------------------------------------------
    always_comb begin
        mul_a0  = '0;
        mul_a1  = '0;
        mul_b0  = '0;
        mul_b1  = '0;
        mul_rnd = '0;
        if (issue) begin
            mul_a0  = in_a0[int'(grant_idx) * d +: d];
            mul_a1  = in_a1[int'(grant_idx) * d +: d];
            mul_b0  = in_b0[int'(grant_idx) * d +: d];
            mul_b1  = in_b1[int'(grant_idx) * d +: d];
            mul_rnd = rnd;
        end
    end

    // -----------------------------------------------------------------------
    // Scheduler registers and a_prev copy
    // a_prev is loaded every cycle, so it mirrors the previous cycle's bus
    // (zero after a non-issue cycle).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            mul_a0_prev <= '0;
            mul_a1_prev <= '0;
        end else begin
            mul_a0_prev <= mul_a0;
            mul_a1_prev <= mul_a1;
            inflight_q  <= issue;
            if (issue) begin
                tag_q <= grant_idx;
                ptr_q <= wrap_idx(int'(grant_idx) + 1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // 2-entry result FIFO
    // A push always lands in the slot not being read (occupancy is at most
    // 1 when pushing), so the head stays stable while stalled.
    // Reset clears the storage so out_id/out0/out1 read zero afterwards; a
    // result in flight during reset is dropped because push is ignored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                id_mem[i] <= '0;
                r0_mem[i] <= '0;
                r1_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                id_mem[wr_q] <= tag_q;
                r0_mem[wr_q] <= mul_out0;
                r1_mem[wr_q] <= mul_out1;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign out_id = id_mem[rd_q];
    assign out0   = r0_mem[rd_q];
    assign out1   = r1_mem[rd_q];

    // The issue rule guarantees a free slot for every push.
    push_when_full_a : assert property (@(posedge clk) disable iff (rst)
        !(push && occ_q == 2'd2));

endmodule
